// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: FSM states and fetch error codes.
package ifu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      OUT  = 2'd3
   } ifu_state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_ACCESS   = 2'd1,
      ERR_MISALIGN = 2'd2
   } ifu_err_e;

   function automatic logic is_misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch unit bus bundle: imem request/response channel plus the decode-side instruction channel.
interface ifu_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   import ifu_pkg::*;

   logic              imem_req_valid_o;
   logic              imem_req_ready_i;
   logic [ADDR_W-1:0] imem_req_addr_o;
   logic              imem_rsp_valid_i;
   logic [INST_W-1:0] imem_rsp_data_i;
   logic              imem_rsp_err_i;
   logic              inst_valid_o;
   logic              inst_ready_i;
   logic [INST_W-1:0] inst_o;
   logic [ADDR_W-1:0] inst_pc_o;
   ifu_err_e          inst_err_o;

   // master = fetch unit, slave = memory/decode environment
   modport master (
      output imem_req_valid_o, imem_req_addr_o,
      input  imem_req_ready_i,
      input  imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
      output inst_valid_o, inst_o, inst_pc_o, inst_err_o,
      input  inst_ready_i
   );

   modport slave (
      input  imem_req_valid_o, imem_req_addr_o,
      output imem_req_ready_i,
      output imem_rsp_valid_i, imem_rsp_data_i, imem_rsp_err_i,
      input  inst_valid_o, inst_o, inst_pc_o, inst_err_o,
      output inst_ready_i
   );

endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch: latch PC, request imem, capture response,
// hand the instruction to decode and pulse the PC write enable on acceptance.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int CNT_W  = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  pc_i,
   output logic               pc_wen_o,
   ifu_fetch_if.master        bus,
   output logic [CNT_W-1:0]   fetch_cnt_o
);

   ifu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [INST_W-1:0] inst_q,  inst_d;
   logic [ADDR_W-1:0] ipc_q,   ipc_d;
   ifu_err_e          err_q,   err_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         inst_q  <= '0;
         ipc_q   <= '0;
         err_q   <= ERR_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         inst_q  <= inst_d;
         ipc_q   <= ipc_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      inst_d  = inst_q;
      ipc_d   = ipc_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            addr_d = pc_i;
            // A misaligned PC never reaches memory; report it straight to decode.
            if (is_misaligned(pc_i[1:0])) begin
               state_d = OUT;
               inst_d  = '0;
               ipc_d   = pc_i;
               err_d   = ERR_MISALIGN;
            end else begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.imem_req_ready_i) state_d = WAIT;
         end
         WAIT: begin
            if (bus.imem_rsp_valid_i) begin
               state_d = OUT;
               ipc_d   = addr_q;
               if (bus.imem_rsp_err_i) begin
                  inst_d = '0;
                  err_d  = ERR_ACCESS;
               end else begin
                  inst_d = bus.imem_rsp_data_i;
                  err_d  = ERR_NONE;
               end
            end
         end
         OUT: begin
            if (bus.inst_ready_i) begin
               state_d = IDLE;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // PC register samples this in the same cycle downstream drives next-PC selects.
   assign pc_wen_o             = (state_q == OUT) && bus.inst_ready_i;
   assign bus.imem_req_valid_o = (state_q == REQ);
   assign bus.imem_req_addr_o  = addr_q;
   assign bus.inst_valid_o     = (state_q == OUT);
   assign bus.inst_o           = inst_q;
   assign bus.inst_pc_o        = ipc_q;
   assign bus.inst_err_o       = err_q;
   assign fetch_cnt_o          = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: memory responder, PC register model and a transaction-level
// expectation of what decode must see, plus directed scenario checks.
module tb_ifu_fetch;

   localparam logic [31:0] FAULT = 32'h8000_0008;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_m, pc_init, jump_tgt;
   logic        jump_en;
   logic        pc_wen;
   logic [63:0] cnt;

   ifu_fetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

   ifu_fetch #(.ADDR_W(32), .INST_W(32), .CNT_W(64)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_i        (pc_m),
      .pc_wen_o    (pc_wen),
      .bus         (bus),
      .fetch_cnt_o (cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic ok, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
      chk(nm, act === exp, act, exp);
   endtask

   // Reference memory contents and what decode must see for a given PC
   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'h0000_0413 : ((a ^ 32'h5a5a_0000) | 32'h3);
   endfunction
   function automatic logic [31:0] exp_inst(input logic [31:0] a);
      return (a[1:0] != 2'b00 || a == FAULT) ? 32'h0 : memf(a);
   endfunction
   function automatic logic [1:0] exp_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) ? 2'd2 : (a == FAULT) ? 2'd1 : 2'd0;
   endfunction

   // ---------------- memory responder ----------------
   typedef struct {
      int          due;
      logic [31:0] data;
      logic        err;
   } rsp_t;
   rsp_t        rq[$];
   int          cyc = 0;
   int          hs_cnt = 0;
   int          delay = 0;
   logic        junk = 1'b0;
   logic        spur = 1'b0;
   logic        hs_s = 1'b0;
   logic [31:0] hs_addr = '0;

   initial begin
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rsp_data_i  = '0;
      bus.imem_rsp_err_i   = 1'b0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (hs_s) begin
            rsp_t r;
            r.due  = cyc + delay;
            r.err  = !junk && (hs_addr == FAULT);
            r.data = junk ? 32'hBAD0_BAD0 : (hs_addr == FAULT) ? 32'hCAFE_0013 : memf(hs_addr);
            rq.push_back(r);
            hs_cnt++;
         end
         bus.imem_rsp_valid_i = 1'b0;
         bus.imem_rsp_data_i  = '0;
         bus.imem_rsp_err_i   = 1'b0;
         if (rq.size() > 0 && rq[0].due <= cyc) begin
            bus.imem_rsp_valid_i = 1'b1;
            bus.imem_rsp_data_i  = rq[0].data;
            bus.imem_rsp_err_i   = rq[0].err;
            void'(rq.pop_front());
         end else if (spur) begin
            bus.imem_rsp_valid_i = 1'b1;
            bus.imem_rsp_data_i  = 32'hFFFF_FFFF;
            bus.imem_rsp_err_i   = 1'b1;
         end
      end
   end

   // ---------------- PC register model ----------------
   logic acc_s = 1'b0;
   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst)       pc_m = pc_init;
         else if (acc_s) pc_m = jump_en ? jump_tgt : pc_m + 32'd4;
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [63:0] cnt_m = '0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr = '0;
   logic        rv, iv;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            cnt_m = '0; prev_stall = 1'b0; acc_s = 1'b0; hs_s = 1'b0;
         end else begin
            rv = bus.imem_req_valid_o;
            iv = bus.inst_valid_o;
            chk("excl_valid", !(rv && iv), {62'd0, rv, iv}, 64'd0);
            chk_eq("wen_gate", pc_wen, iv && bus.inst_ready_i);
            if (rv) chk("req_addr", bus.imem_req_addr_o == pc_m && pc_m[1:0] == 2'b00,
                        bus.imem_req_addr_o, pc_m);
            if (prev_stall) chk("req_hold", rv && bus.imem_req_addr_o == prev_addr,
                                {31'd0, rv, bus.imem_req_addr_o}, {32'd1, prev_addr});
            if (iv) begin
               chk_eq("inst", bus.inst_o, exp_inst(pc_m));
               chk_eq("inst_pc", bus.inst_pc_o, pc_m);
               chk_eq("inst_err", bus.inst_err_o, exp_err(pc_m));
            end
            chk_eq("fetch_cnt", cnt, cnt_m);
            prev_stall = rv && !bus.imem_req_ready_i;
            prev_addr  = bus.imem_req_addr_o;
            hs_s       = rv && bus.imem_req_ready_i;
            hs_addr    = bus.imem_req_addr_o;
            acc_s      = iv && bus.inst_ready_i;
            if (acc_s) cnt_m = cnt_m + 64'd1;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_iv(input logic want, input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.inst_valid_o !== want && n < 60);
      if (bus.inst_valid_o !== want) chk(nm, 1'b0, {63'd0, bus.inst_valid_o}, {63'd0, want});
   endtask

   task automatic reset_checks(input string nm);
      chk_eq({nm, "_valids"}, {bus.imem_req_valid_o, bus.inst_valid_o, pc_wen}, 3'b000);
      chk_eq({nm, "_addr"}, bus.imem_req_addr_o, 32'h0);
      chk_eq({nm, "_inst"}, bus.inst_o, 32'h0);
      chk_eq({nm, "_ipc"}, bus.inst_pc_o, 32'h0);
      chk_eq({nm, "_err"}, bus.inst_err_o, 2'd0);
      chk_eq({nm, "_cnt"}, cnt, 64'd0);
   endtask

   int hs0;
   int n;

   initial begin
      pc_init = 32'h8000_0000;
      pc_m = pc_init;
      jump_en = 1'b0;
      jump_tgt = '0;
      rst = 1'b0;
      bus.imem_req_ready_i = 1'b1;
      bus.inst_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_checks("rst");

      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk_eq("idle_no_req", bus.imem_req_valid_o, 1'b0);
      @(negedge clk);
      chk_eq("first_req_v", bus.imem_req_valid_o, 1'b1);
      chk_eq("first_req_a", bus.imem_req_addr_o, 32'h8000_0000);
      @(negedge clk);
      chk_eq("wait_valids", {bus.imem_req_valid_o, bus.inst_valid_o}, 2'b00);
      @(negedge clk);
      chk_eq("first_iv", bus.inst_valid_o, 1'b1);
      chk_eq("first_inst", bus.inst_o, 32'h0000_0413);
      chk_eq("first_pc", bus.inst_pc_o, 32'h8000_0000);
      chk_eq("first_wen", pc_wen, 1'b1);

      // memory stalls the second request for 5 cycles
      @(posedge clk); #1 bus.imem_req_ready_i = 1'b0;
      @(negedge clk);
      chk_eq("first_cnt", cnt, 64'd1);
      chk_eq("first_wen_off", pc_wen, 1'b0);
      repeat (5) begin
         @(negedge clk);
         chk("stall_req", bus.imem_req_valid_o && bus.imem_req_addr_o == 32'h8000_0004,
             {31'd0, bus.imem_req_valid_o, bus.imem_req_addr_o}, {32'd1, 32'h8000_0004});
      end
      @(posedge clk); #1 begin hs0 = hs_cnt; bus.imem_req_ready_i = 1'b1; end
      wait_iv(1'b1, "stall_out_to");
      chk_eq("stall_pc", bus.inst_pc_o, 32'h8000_0004);
      chk_eq("stall_one_hs", hs_cnt - hs0, 1);

      // access fault at 0x80000008
      wait_iv(1'b0, "err_gap_to");
      wait_iv(1'b1, "err_out_to");
      chk_eq("err_pc", bus.inst_pc_o, 32'h8000_0008);
      chk_eq("err_code", bus.inst_err_o, 2'd1);
      chk_eq("err_inst", bus.inst_o, 32'h0);
      chk_eq("err_wen", pc_wen, 1'b1);
      @(negedge clk);
      chk_eq("err_cnt", cnt, 64'd3);

      // jump to a misaligned PC after 0x8000000C, then back to 0x80000010
      @(posedge clk); #1 begin jump_en = 1'b1; jump_tgt = 32'h8000_0002; end
      wait_iv(1'b1, "c_out_to");
      chk_eq("c_pc", bus.inst_pc_o, 32'h8000_000C);
      @(posedge clk); #1 begin jump_tgt = 32'h8000_0010; hs0 = hs_cnt; end
      wait_iv(1'b1, "mis_out_to");
      chk_eq("mis_pc", bus.inst_pc_o, 32'h8000_0002);
      chk_eq("mis_err", bus.inst_err_o, 2'd2);
      chk_eq("mis_inst", bus.inst_o, 32'h0);
      chk_eq("mis_wen", pc_wen, 1'b1);
      chk_eq("mis_noreq", hs_cnt - hs0, 0);

      // decode stalls; spurious responses must not disturb the held instruction
      @(posedge clk); #1 begin jump_en = 1'b0; bus.inst_ready_i = 1'b0; end
      wait_iv(1'b1, "rdy_out_to");
      chk_eq("rdy_pc", bus.inst_pc_o, 32'h8000_0010);
      @(posedge clk); #1 spur = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rdy_hold", bus.inst_valid_o && !pc_wen && bus.inst_o == 32'hDA5A_0013
             && bus.inst_pc_o == 32'h8000_0010,
             {bus.inst_valid_o, pc_wen, bus.inst_o}, {2'b10, 32'hDA5A_0013});
      end
      @(posedge clk); #1 begin spur = 1'b0; bus.inst_ready_i = 1'b1; end
      @(negedge clk);
      chk_eq("rdy_wen", pc_wen, 1'b1);
      chk_eq("rdy_inst", bus.inst_o, 32'hDA5A_0013);
      @(posedge clk); #1 begin delay = 2; junk = 1'b1; pc_init = 32'h8000_0100; end
      @(negedge clk);
      chk_eq("rdy_wen_once", pc_wen, 1'b0);
      chk_eq("rdy_cnt", cnt, 64'd6);

      // reset while waiting for a slow response; that response arrives late
      n = 0;
      while (bus.imem_req_valid_o !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk_eq("rw_req", bus.imem_req_valid_o, 1'b1);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      reset_checks("rw_rst");
      @(posedge clk); #1 begin rst = 1'b1; delay = 0; junk = 1'b0; end
      wait_iv(1'b1, "rw_out_to");
      chk_eq("rw_pc", bus.inst_pc_o, 32'h8000_0100);
      chk_eq("rw_inst", bus.inst_o, 32'hDA5A_0103);
      chk_eq("rw_err", bus.inst_err_o, 2'd0);
      @(negedge clk);
      chk_eq("rw_cnt", cnt, 64'd1);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
